// File: rtl/result_packer.sv
`default_nettype none
// ============================================================================
// result_packer: pairs upstream results into 2-lane words and queues them in
// a first-word-fall-through FIFO; flush emits a half-filled word.  Rev 1.0
// ============================================================================
module result_packer #(
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [OUT_WIDTH-1:0]       in_data,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*OUT_WIDTH-1:0]     out_data,
  output logic                       out_partial,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] c_depth    = LW'(DEPTH);
  localparam logic [0:0]    c_st_empty = 1'b0;
  localparam logic [0:0]    c_st_half  = 1'b1;

  logic [0:0]           r_state;
  logic [OUT_WIDTH-1:0] r_low;
  logic                 r_pend;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic [2*OUT_WIDTH-1:0] r_mem [DEPTH];
  logic                   r_mem_partial [DEPTH];

  logic                   w_full;
  logic                   w_accept;
  logic                   w_eff_flush;
  logic                   w_pop;
  logic                   w_push;
  logic [2*OUT_WIDTH-1:0] w_push_data;
  logic                   w_push_partial;
  logic [0:0]             w_next_state;
  logic [OUT_WIDTH-1:0]   w_next_low;
  logic                   w_next_pend;

  assign w_full      = (r_level == c_depth);
  assign in_ready    = !rst && !w_full;
  assign w_accept    = in_valid && in_ready;
  // A flush that was blocked by a full FIFO stays armed until it can write.
  assign w_eff_flush = flush || r_pend;
  assign out_valid   = (r_level != '0);
  assign w_pop       = out_ready && out_valid;
  assign out_data    = r_mem[r_rd_ptr];
  assign out_partial = out_valid && r_mem_partial[r_rd_ptr];
  assign fifo_level  = r_level;

  always_comb begin
    w_push         = 1'b0;
    w_push_data    = '0;
    w_push_partial = 1'b0;
    w_next_state   = r_state;
    w_next_low     = r_low;
    w_next_pend    = r_pend;
    if (w_accept) begin
      if (r_state == c_st_half) begin
        w_push       = 1'b1;
        w_push_data  = {in_data, r_low};
        w_next_state = c_st_empty;
        w_next_pend  = 1'b0;
      end else if (w_eff_flush) begin
        w_push         = 1'b1;
        w_push_data    = {{OUT_WIDTH{1'b0}}, in_data};
        w_push_partial = 1'b1;
        w_next_pend    = 1'b0;
      end else begin
        w_next_state = c_st_half;
        w_next_low   = in_data;
      end
    end else if (w_eff_flush) begin
      if (r_state == c_st_half) begin
        if (!w_full) begin
          w_push         = 1'b1;
          w_push_data    = {{OUT_WIDTH{1'b0}}, r_low};
          w_push_partial = 1'b1;
          w_next_state   = c_st_empty;
          w_next_pend    = 1'b0;
        end else begin
          w_next_pend = 1'b1;
        end
      end else begin
        w_next_pend = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_st_empty;
      r_low    <= '0;
      r_pend   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_state <= w_next_state;
      r_low   <= w_next_low;
      r_pend  <= w_next_pend;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]         <= w_push_data;
      r_mem_partial[r_wr_ptr] <= w_push_partial;
    end
  end

endmodule
`default_nettype wire
